call_ret_ctrl: RTL and testbench
================================

# call_ret_ctrl

Call/return sequencer that drives the processor's hardware return-address stack from the initiator side. Sits between instruction decode and the `stack` block: on CALL it pushes the return address and redirects the PC to the target. On RET it pops the stack, waits for the stack's registered output, and redirects the PC to the popped address. It tracks stack occupancy so fetch never overflows or underflows the stack, and it stalls decode while a return is in flight.

## Interface
Parameters:
- `WIDTH`, 16: address/data width; matches stack `WIDTH`.
- `DEPTH`, 256: stack entries; matches stack `DEPTH`.

Ports:
- `clk`, in, 1: single clock; all logic on rising edge.
- `reset`, in, 1: synchronous, active-high. The same reset drives the stack.
- `call`, in, 1: CALL decoded this cycle. Sampled only when `stall`=0.
- `ret`, in, 1: RET decoded this cycle. Sampled only when `stall`=0.
- `pc`, in, WIDTH: address of the CALL instruction.
- `target`, in, WIDTH: CALL destination.
- `stall`, out, 1: decode hold; combinational, equal to (state != IDLE).
- `pc_load`, out, 1: one-cycle registered pulse; fetch loads `pc_next`.
- `pc_next`, out, WIDTH: registered redirect address.
- `stk_push`, out, 1: registered push pulse to the stack.
- `stk_pop`, out, 1: registered pop pulse to the stack.
- `stk_data`, out, WIDTH: registered push data.
- `stk_out`, in, WIDTH: stack's registered pop output.
- `depth`, out, clog2(DEPTH)+1: current occupancy, 0..DEPTH.
- `ovf`, out, 1: sticky overflow flag; cleared only by reset.
- `unf`, out, 1: sticky underflow flag; cleared only by reset.

## Operation
- FSM states: IDLE, POP, WAIT.
- IDLE, `call`=1:
  - Next edge: `stk_push`=1, `stk_data`=`pc`+1 (mod 2^WIDTH), `pc_load`=1, `pc_next`=`target`, `depth`+1.
  - State remains IDLE.
- IDLE, `ret`=1, `call`=0:
  - Next edge: `stk_pop`=1, `depth`-1, state goes to POP.
- POP: the stack updates `stk_out` on this cycle's closing edge; the block goes to WAIT with all pulses 0.
- WAIT: on the next edge, `pc_next`=`stk_out`, `pc_load`=1, state goes to IDLE.
- `call` and `ret` both high in IDLE: CALL wins, RET is dropped with no flag.
- `stk_push`, `stk_pop` and `pc_load` are single-cycle pulses, 0 otherwise. `stk_push` and `stk_pop` are never high together.
- `pc_next` and `stk_data` hold their last value between pulses.

## Timing
- Reset values: state=IDLE, `pc_load`/`stk_push`/`stk_pop`=0, `pc_next`/`stk_data`=0, `depth`=0, `ovf`/`unf`=0, so `stall`=0.
- CALL latency: 1 cycle from sampled `call` to `pc_load` and `stk_push` (same edge).
- RET latency: 3 cycles from sampled `ret` to `pc_load`. `stall` is high for 2 cycles (POP, WAIT), so back-to-back CALLs sustain 1 per cycle and RET throughput is 1 per 3 cycles.
- Reset mid-RET (in POP or WAIT): return to IDLE, no `pc_load` is issued, `depth`=0.
- `pc`=all-ones: return address wraps to 0.

## Configuration
- Macro `CALLRET_GUARD_EN`, defined:
  - CALL with `depth`==DEPTH: no push, no `pc_load`, `ovf` set, `depth` unchanged.
  - RET with `depth`==0: no pop, stays in IDLE, `unf` set, `depth` unchanged.
- Undefined:
  - No guards: every CALL/RET is forwarded to the stack.
  - `ovf`/`unf` tied 0.
  - `depth` wraps modulo 2^(clog2(DEPTH)+1).

## Test plan
- Reset then idle -> all outputs 0, `stall`=0, for 5 cycles.
- CALL with `pc`=0x0010, `target`=0x0200 -> next cycle `stk_push`=1, `stk_data`=0x0011, `pc_load`=1, `pc_next`=0x0200, `depth`=1.
- After that CALL, RET -> `stk_pop` 1 cycle later, `stall`=1 for 2 cycles, `pc_load`=1 with `pc_next`=0x0011 3 cycles after `ret`, `depth`=0.
- Nested CALLs from `pc`=0x0100, 0x0200, 0x0300, then 3 RETs -> `pc_next` sequence 0x0301, 0x0201, 0x0101.
- With guard enabled: RET at `depth`=0 -> no `stk_pop`, `unf`=1, still set 10 cycles later. Then DEPTH+1 CALLs -> last CALL gives no push, `ovf`=1, `depth`=DEPTH.
- CALL and RET high together with `pc`=0xFFFF -> push of 0x0000, no pop. Separately, reset asserted during WAIT -> no `pc_load`, `depth`=0.

Source files
------------

// File: rtl/call_ret_ctrl.sv
// Call/return sequencer driving a hardware return-address stack.
// Define CALLRET_GUARD_EN to block stack overflow/underflow and raise sticky ovf/unf flags.
module call_ret_ctrl #(
    parameter  int WIDTH = 16,
    parameter  int DEPTH = 256,
    localparam int DW    = $clog2(DEPTH) + 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             call,
    input  logic             ret,
    input  logic [WIDTH-1:0] pc,
    input  logic [WIDTH-1:0] target,
    output logic             stall,
    output logic             pc_load,
    output logic [WIDTH-1:0] pc_next,
    output logic             stk_push,
    output logic             stk_pop,
    output logic [WIDTH-1:0] stk_data,
    input  logic [WIDTH-1:0] stk_out,
    output logic [DW-1:0]    depth,
    output logic             ovf,
    output logic             unf,
    output logic [1:0]       dbg_state
);

    // Handshake: call/ret are accepted on a rising edge only while stall is low;
    // pc_load, stk_push and stk_pop are one-cycle registered pulses.
    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_POP  = 2'd1,
        S_WAIT = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic             pc_load_q, pc_load_d;
    logic             push_q, push_d;
    logic             pop_q, pop_d;
    logic [WIDTH-1:0] pc_next_q, pc_next_d;
    logic [WIDTH-1:0] stk_data_q, stk_data_d;
    logic [DW-1:0]    depth_q, depth_d;
    logic             ovf_q, ovf_d;
    logic             unf_q, unf_d;
    logic             full, empty;

`ifdef CALLRET_GUARD_EN
    assign full  = (depth_q == DW'(DEPTH));
    assign empty = (depth_q == '0);
`else
    // Without guards the stack sees every request and the flags never set.
    assign full  = 1'b0;
    assign empty = 1'b0;
`endif

    always_comb begin
        state_d    = state_q;
        pc_load_d  = 1'b0;
        push_d     = 1'b0;
        pop_d      = 1'b0;
        pc_next_d  = pc_next_q;
        stk_data_d = stk_data_q;
        depth_d    = depth_q;
        ovf_d      = ovf_q;
        unf_d      = unf_q;
        case (state_q)
            S_IDLE: begin
                // CALL has priority; a simultaneous RET is silently dropped.
                if (call) begin
                    if (full) begin
                        ovf_d = 1'b1;
                    end else begin
                        push_d     = 1'b1;
                        stk_data_d = pc + WIDTH'(1);
                        pc_load_d  = 1'b1;
                        pc_next_d  = target;
                        depth_d    = depth_q + DW'(1);
                    end
                end else if (ret) begin
                    if (empty) begin
                        unf_d = 1'b1;
                    end else begin
                        pop_d   = 1'b1;
                        depth_d = depth_q - DW'(1);
                        state_d = S_POP;
                    end
                end
            end
            S_POP: begin
                state_d = S_WAIT;
            end
            S_WAIT: begin
                // stk_out was refreshed by the stack at the end of POP.
                pc_next_d = stk_out;
                pc_load_d = 1'b1;
                state_d   = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= S_IDLE;
            pc_load_q  <= 1'b0;
            push_q     <= 1'b0;
            pop_q      <= 1'b0;
            pc_next_q  <= '0;
            stk_data_q <= '0;
            depth_q    <= '0;
            ovf_q      <= 1'b0;
            unf_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            pc_load_q  <= pc_load_d;
            push_q     <= push_d;
            pop_q      <= pop_d;
            pc_next_q  <= pc_next_d;
            stk_data_q <= stk_data_d;
            depth_q    <= depth_d;
            ovf_q      <= ovf_d;
            unf_q      <= unf_d;
        end
    end

    assign stall     = (state_q != S_IDLE);
    assign pc_load   = pc_load_q;
    assign pc_next   = pc_next_q;
    assign stk_push  = push_q;
    assign stk_pop   = pop_q;
    assign stk_data  = stk_data_q;
    assign depth     = depth_q;
    assign ovf       = ovf_q;
    assign unf       = unf_q;
    assign dbg_state = state_q;

endmodule

// File: tb/tb_call_ret_ctrl.sv
// Bench for call_ret_ctrl: behavioural return-address model, stack model and scoreboard.
module tb_call_ret_ctrl;
  localparam int W = 16;
  localparam int DEPTH = 16;
  localparam int DW = $clog2(DEPTH) + 1;
`ifdef CALLRET_GUARD_EN
  localparam bit GUARD = 1'b1;
`else
  localparam bit GUARD = 1'b0;
`endif

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic call = 1'b0, ret = 1'b0;
  logic [W-1:0] pc = '0, target = '0;
  logic stall, pc_load, stk_push, stk_pop, ovf, unf;
  logic [W-1:0] pc_next, stk_data, stk_out;
  logic [DW-1:0] depth;
  logic [1:0] dbg_state;

  call_ret_ctrl #(.WIDTH(W), .DEPTH(DEPTH)) dut (
    .clk(clk), .reset(reset), .call(call), .ret(ret), .pc(pc), .target(target),
    .stall(stall), .pc_load(pc_load), .pc_next(pc_next), .stk_push(stk_push),
    .stk_pop(stk_pop), .stk_data(stk_data), .stk_out(stk_out), .depth(depth),
    .ovf(ovf), .unf(unf), .dbg_state(dbg_state)
  );

  // clock / reset / cycle counter
  always #5 clk = ~clk;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // stack block model: registered pop output
  logic [W-1:0] stk_mem[$];
  always @(posedge clk) begin
    if (reset) begin
      stk_mem.delete();
      stk_out <= '0;
    end else if (stk_push) begin
      stk_mem.push_back(stk_data);
    end else if (stk_pop) begin
      if (stk_mem.size() > 0) stk_out <= stk_mem.pop_back();
    end
  end

  // reference model state
  logic [W-1:0] ret_q[$];
  int mdepth = 0;
  int busy = 0;
  bit m_ovf = 0, m_unf = 0;

  // scoreboard queues
  logic [W-1:0] exp_q[$];       // expected pc_next on each pc_load
  int exp_load_cyc_q[$];
  logic [W-1:0] exp_push_q[$];  // expected stk_data on each stk_push
  int exp_push_cyc_q[$];
  int exp_pop_cyc_q[$];

  int n_checks = 0;
  int n_fail = 0;
  bit mon_en = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic clear_model();
    ret_q.delete();
    mdepth = 0;
    busy = 0;
    m_ovf = 0;
    m_unf = 0;
    exp_q.delete();
    exp_load_cyc_q.delete();
    exp_push_q.delete();
    exp_push_cyc_q.delete();
    exp_pop_cyc_q.delete();
  endtask

  // driver: one decode cycle
  task automatic step(input logic c, input logic r, input logic [W-1:0] p, input logic [W-1:0] t);
    bit acc_call, acc_ret, ovf_ev, unf_ev;
    int now;
    call = c; ret = r; pc = p; target = t;
    check("stall", 32'(stall), 32'(busy != 0));
    acc_call = 0; acc_ret = 0; ovf_ev = 0; unf_ev = 0;
    if (busy == 0) begin
      if (c) begin
        if (GUARD && mdepth == DEPTH) ovf_ev = 1; else acc_call = 1;
      end else if (r) begin
        if (GUARD && mdepth == 0) unf_ev = 1; else acc_ret = 1;
      end
    end
    @(posedge clk);
    #1;
    now = cyc;
    if (busy > 0) busy--;
    if (acc_call) begin
      exp_push_q.push_back(p + W'(1));
      exp_push_cyc_q.push_back(now);
      exp_q.push_back(t);
      exp_load_cyc_q.push_back(now);
      ret_q.push_back(p + W'(1));
      mdepth++;
    end
    if (acc_ret) begin
      exp_pop_cyc_q.push_back(now);
      exp_q.push_back(ret_q.pop_back());
      exp_load_cyc_q.push_back(now + 2);
      mdepth--;
      busy = 2;
    end
    if (ovf_ev) m_ovf = 1;
    if (unf_ev) m_unf = 1;
    call = 0; ret = 0;
  endtask

  task automatic do_reset(input int n);
    reset = 1; call = 0; ret = 0;
    @(posedge clk);
    #1;
    clear_model();
    check("rst_pc_load", 32'(pc_load), 0);
    check("rst_push", 32'(stk_push), 0);
    check("rst_pop", 32'(stk_pop), 0);
    check("rst_pc_next", 32'(pc_next), 0);
    check("rst_stk_data", 32'(stk_data), 0);
    check("rst_depth", 32'(depth), 0);
    check("rst_stall", 32'(stall), 0);
    repeat (n - 1) @(posedge clk);
    #1;
    reset = 0;
  endtask

  // monitor: compares DUT outputs with the scoreboard mid-cycle
  initial begin
    forever begin
      @(negedge clk);
      if (mon_en) begin
        if (pc_load) begin
          if (exp_q.size() == 0) check("unexpected_load", 1, 0);
          else begin
            check("load_addr", 32'(pc_next), 32'(exp_q.pop_front()));
            check("load_cycle", 32'(cyc), 32'(exp_load_cyc_q.pop_front()));
          end
        end else begin
          while (exp_load_cyc_q.size() > 0 && exp_load_cyc_q[0] <= cyc) begin
            check("load_missing", 0, 1);
            void'(exp_load_cyc_q.pop_front());
            void'(exp_q.pop_front());
          end
        end
        if (stk_push) begin
          if (exp_push_q.size() == 0) check("unexpected_push", 1, 0);
          else begin
            check("push_data", 32'(stk_data), 32'(exp_push_q.pop_front()));
            check("push_cycle", 32'(cyc), 32'(exp_push_cyc_q.pop_front()));
          end
        end else begin
          while (exp_push_cyc_q.size() > 0 && exp_push_cyc_q[0] <= cyc) begin
            check("push_missing", 0, 1);
            void'(exp_push_cyc_q.pop_front());
            void'(exp_push_q.pop_front());
          end
        end
        if (stk_pop) begin
          if (exp_pop_cyc_q.size() == 0) check("unexpected_pop", 1, 0);
          else check("pop_cycle", 32'(cyc), 32'(exp_pop_cyc_q.pop_front()));
        end else begin
          while (exp_pop_cyc_q.size() > 0 && exp_pop_cyc_q[0] <= cyc) begin
            check("pop_missing", 0, 1);
            void'(exp_pop_cyc_q.pop_front());
          end
        end
        check("push_pop_excl", 32'(stk_push & stk_pop), 0);
        check("depth", 32'(depth), 32'(mdepth));
        check("ovf", 32'(ovf), 32'(m_ovf));
        check("unf", 32'(unf), 32'(m_unf));
      end
    end
  end

  // stimulus
  initial begin
    logic c, r;
    do_reset(3);
    mon_en = 1;
    repeat (5) step(0, 0, '0, '0);

    // single CALL then RET
    step(1, 0, 16'h0010, 16'h0200);
    step(0, 1, '0, '0);
    repeat (3) step(0, 0, '0, '0);

    // nested CALLs then RETs: returns 0x0301, 0x0201, 0x0101
    step(1, 0, 16'h0100, 16'h1000);
    step(1, 0, 16'h0200, 16'h2000);
    step(1, 0, 16'h0300, 16'h3000);
    repeat (3) begin
      step(0, 1, '0, '0);
      step(0, 1, '0, '0);  // dropped: stalled
      step(0, 0, '0, '0);
    end

    // CALL and RET together with pc wrap
    step(1, 1, 16'hFFFF, 16'h1234);
    // RET, then reset while in WAIT: no pc_load, depth cleared
    step(0, 1, '0, '0);
    step(0, 0, '0, '0);
    do_reset(2);
    repeat (3) step(0, 0, '0, '0);

    if (GUARD) begin
      step(0, 1, '0, '0);
      repeat (10) step(0, 0, '0, '0);
      for (int i = 0; i < DEPTH + 1; i++) step(1, 0, W'(16'h0400 + i), W'(16'h5000 + i));
      repeat (3) step(0, 0, '0, '0);
    end

    // randomized traffic
    for (int i = 0; i < 400; i++) begin
      c = ($urandom_range(0, 99) < 45);
      r = ($urandom_range(0, 99) < 45);
      if (!GUARD && busy == 0) begin
        if (mdepth == DEPTH) c = 0;
        if (mdepth == 0) r = 0;
      end
      step(c, r, W'($urandom), W'($urandom));
    end

    repeat (5) step(0, 0, '0, '0);
    check("drain_load", 32'(exp_q.size()), 0);
    check("drain_push", 32'(exp_push_q.size()), 0);
    check("drain_pop", 32'(exp_pop_cyc_q.size()), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end
endmodule
